display_scan_controller: RTL and testbench

//  Time-multiplexed scan driver for the 4-digit 7-segment display. Holds a 16-bit
//  hex value, steps dig_sel 0->1->2->3->0 at a fixed refresh rate and presents
//  the matching nibble and decimal point for the segment decoder. dig_sel feeds
//  the digit-enable decoder. Inserts blanking between digits to stop ghosting.
//  New values are taken only at frame boundaries, so no frame is ever torn.

---
 rtl/display_scan_controller_pkg.sv | 31 +++
 rtl/display_scan_controller_scan_tick_gen.sv | 33 +++
 rtl/display_scan_controller.sv | 96 +++++++++
 tb/tb_display_scan_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_controller_pkg.sv
// rtl/display_scan_controller_pkg.sv - shared widths, scan FSM states and digit helpers
package display_scan_controller_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_SEL_W  = 2;
  localparam int NIBBLE_W   = 4;
  localparam int SHADOW_W   = NUM_DIGITS * (NIBBLE_W + 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Shadow layout: {dp[3:0], nibble3, nibble2, nibble1, nibble0}
  function automatic logic [NIBBLE_W-1:0] digit_nibble(input logic [SHADOW_W-1:0] s,
                                                       input logic [DIG_SEL_W-1:0] idx);
    return s[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

  function automatic logic digit_dp(input logic [SHADOW_W-1:0] s,
                                    input logic [DIG_SEL_W-1:0] idx);
    return s[NUM_DIGITS*NIBBLE_W + int'(idx)];
  endfunction

  function automatic logic leading_zero(input logic [SHADOW_W-1:0] s,
                                        input logic [DIG_SEL_W-1:0] idx);
    return (idx != '0) &&
           ((s[NUM_DIGITS*NIBBLE_W-1:0] >> (idx*NIBBLE_W)) == '0);
  endfunction

endpackage

// File: rtl/display_scan_controller_scan_tick_gen.sv
// rtl/display_scan_controller_scan_tick_gen.sv - digit slot counter with slot_end/blank_end strobes
module scan_tick_gen #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_slot_end,
  output logic o_blank_end
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_count;
  logic          w_slot_end;

  assign w_slot_end = (r_count == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_slot_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the last blanking cycle so the registered FSM shows from count==BLANK_CYCLES
  assign o_blank_end = (BLANK_CYCLES > 0) && (r_count == CW'(BLANK_CYCLES - 1));
  assign o_slot_end  = w_slot_end;

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit 7-seg scan driver with frame-aligned value updates
// Optional: LEADING_ZERO_SUPPRESS_EN blanks leading zero digits 1..3.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          value,
  input  logic [3:0]           dp_in,
  input  logic                 load,
  output logic [DIG_SEL_W-1:0] dig_sel,
  output logic [NIBBLE_W-1:0]  nibble,
  output logic                 dp,
  output logic                 blank,
  output logic                 frame_done
);

  scan_state_t           r_state, w_state_next;
  logic [SHADOW_W-1:0]   r_shadow, r_pend, w_shadow_next;
  logic                  r_pend_vld;
  logic                  w_slot_end, w_blank_end, w_wrap, w_suppress, w_blank_next;
  logic [DIG_SEL_W-1:0]  w_dig_next;

  scan_tick_gen #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_slot_end  (w_slot_end),
    .o_blank_end (w_blank_end)
  );

  assign w_wrap     = w_slot_end && (dig_sel == DIG_SEL_W'(NUM_DIGITS - 1));
  assign w_dig_next = w_slot_end ? dig_sel + 1'b1 : dig_sel;

  // A load in the wrap cycle bypasses pending so it is shown from slot 0 of the new frame
  always_comb begin
    w_shadow_next = r_shadow;
    if (w_wrap) begin
      if (load) begin
        w_shadow_next = {dp_in, value};
      end else if (r_pend_vld) begin
        w_shadow_next = r_pend;
      end
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  assign w_suppress = leading_zero(w_shadow_next, w_dig_next);
`else
  assign w_suppress = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BLANK: if (BLANK_CYCLES == 0 || w_blank_end) w_state_next = ST_SHOW;
      ST_SHOW:  if (w_slot_end) w_state_next = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      default:  w_state_next = ST_BLANK;
    endcase
    w_blank_next = (w_state_next == ST_BLANK) || w_suppress;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BLANK;
      dig_sel    <= '0;
      nibble     <= '0;
      dp         <= 1'b0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      r_shadow   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      dig_sel    <= w_dig_next;
      nibble     <= digit_nibble(w_shadow_next, w_dig_next);
      dp         <= digit_dp(w_shadow_next, w_dig_next) & ~w_blank_next;
      blank      <= w_blank_next;
      frame_done <= w_wrap;
      r_shadow   <= w_shadow_next;
      if (load && !w_wrap) begin
        r_pend     <= {dp_in, value};
        r_pend_vld <= 1'b1;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - randomized self-checking bench against a frame-level display model
module tb_display_scan_controller;

  localparam int CD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  logic [1:0] dig_sel, dig_sel_z;
  logic [3:0] nibble, nibble_z;
  logic       dp, dp_z, blank, blank_z, frame_done, frame_done_z;
  logic [8:0] obs, obs_z, exp_v;

  int errors = 0;
  int checks = 0;
  int n = 0;
  logic [19:0] m_shown = '0;
  logic [19:0] m_pend = '0;
  bit          m_pend_vld = 0;

  display_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .dig_sel(dig_sel), .nibble(nibble), .dp(dp), .blank(blank), .frame_done(frame_done)
  );

  display_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .dig_sel(dig_sel_z), .nibble(nibble_z), .dp(dp_z), .blank(blank_z), .frame_done(frame_done_z)
  );

  assign obs   = {dig_sel, nibble, dp, blank, frame_done};
  assign obs_z = {dig_sel_z, nibble_z, dp_z, blank_z, frame_done_z};

  always #5 clk = ~clk;

  // Cycle n counts rising edges since reset release; frames are FR cycles long
  function automatic logic [8:0] model_out(input int bc);
    int cnt = n % CD;
    int dig = (n / CD) % 4;
    logic blk;
    logic [19:0] s = m_shown;
    blk = (bc == 0) ? (n == 0) : (cnt < bc);
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (dig != 0 && (s[15:0] >> (4 * dig)) == 16'd0) blk = 1'b1;
`endif
    return {2'(dig), s[4*dig +: 4], s[16+dig] & ~blk, blk, (n > 0 && n % FR == 0)};
  endfunction

  task automatic step();
    @(negedge clk);
    n++;
    if (n % FR == 0 && m_pend_vld) begin
      m_shown = m_pend;
      m_pend_vld = 0;
    end
  endtask

  task automatic drive(input bit ld, input logic [15:0] v, input logic [3:0] d);
    load = ld; value = v; dp_in = d;
    if (ld) begin
      m_pend = {d, v};
      m_pend_vld = 1;
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    n = 0; m_shown = '0; m_pend = '0; m_pend_vld = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 16'h0, 4'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 9'h002) begin errors++; $display("FAIL reset_hold got %h want %h", obs, 9'h002); end
    checks++;
    if (obs_z !== 9'h002) begin errors++; $display("FAIL reset_hold_bc0 got %h want %h", obs_z, 9'h002); end
    release_reset();
    checks++; exp_v = model_out(BC);
    if (obs !== exp_v) begin errors++; $display("FAIL reset_n0 got %h want %h", obs, exp_v); end
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL idle_scan n=%0d got %h want %h", n, obs, exp_v); end
      checks++; exp_v = model_out(0);
      if (obs_z !== exp_v) begin errors++; $display("FAIL idle_bc0 n=%0d got %h want %h", n, obs_z, exp_v); end
      drive(0, 16'h0, 4'h0);
    end
  endtask

  task automatic test_load_basic();
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL load_1234 n=%0d got %h want %h", n, obs, exp_v); end
      drive(i == 2, 16'h1234, 4'h0);
    end
  endtask

  task automatic test_same_frame_loads();
    while (n % FR != 4) begin
      step();
      drive(0, 16'h0, 4'h0);
    end
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL last_load_wins n=%0d got %h want %h", n, obs, exp_v); end
      if (i == 1)      drive(1, 16'hABCD, 4'h0);
      else if (i == 9) drive(1, 16'h5678, 4'h0);
      else             drive(0, 16'h0, 4'h0);
    end
  endtask

  task automatic test_wrap_load();
    bit done = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL wrap_load n=%0d got %h want %h", n, obs, exp_v); end
      if (!done && n % FR == FR - 1) begin
        done = 1;
        drive(1, 16'h9F00, 4'h0);
      end else begin
        drive(0, 16'h0, 4'h0);
      end
    end
  endtask

  task automatic test_dp();
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL dp_digit2 n=%0d got %h want %h", n, obs, exp_v); end
      drive(i == 0, 16'h8765, 4'b0100);
    end
  endtask

  task automatic test_leading_zero();
    for (int i = 0; i < 5 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL lead_zero n=%0d got %h want %h", n, obs, exp_v); end
      checks++; exp_v = model_out(0);
      if (obs_z !== exp_v) begin errors++; $display("FAIL lead_zero_bc0 n=%0d got %h want %h", n, obs_z, exp_v); end
      if (i == 0)           drive(1, 16'h0042, 4'b0110);
      else if (i == 2 * FR) drive(1, 16'h0000, 4'b1111);
      else                  drive(0, 16'h0, 4'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL random n=%0d got %h want %h", n, obs, exp_v); end
      checks++; exp_v = model_out(0);
      if (obs_z !== exp_v) begin errors++; $display("FAIL random_bc0 n=%0d got %h want %h", n, obs_z, exp_v); end
      drive(($urandom_range(0, 11) == 0) || (n % FR == FR - 1 && $urandom_range(0, 2) == 0),
            16'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_reset_mid_slot();
    while (n % FR != 5) begin
      step();
      drive(0, 16'h0, 4'h0);
    end
    drive(1, 16'hABCD, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL pre_reset n=%0d got %h want %h", n, obs, exp_v); end
      drive(0, 16'h0, 4'h0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 9'h002) begin errors++; $display("FAIL mid_slot_reset got %h want %h", obs, 9'h002); end
    repeat (2) @(negedge clk);
    release_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      checks++; exp_v = model_out(BC);
      if (obs !== exp_v) begin errors++; $display("FAIL pending_lost n=%0d got %h want %h", n, obs, exp_v); end
      drive(0, 16'h0, 4'h0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_same_frame_loads();
    test_wrap_load();
    test_dp();
    test_leading_zero();
    test_random();
    test_reset_mid_slot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
